// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// FSM state encodings and a counter-width helper.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for n passes; a single pass still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand-request / result bundle between an operand source, the sequencer
// and a result consumer.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry_out;

    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_busy, o_done, o_sum, o_carry_out
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_busy, o_done, o_sum, o_carry_out
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit adder slice; the only arithmetic in the sequencer.
module nibble_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout
);
    // One nibble plus carry, widened by a bit to expose the carry out.
    always_comb begin
        {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{NIB_W{1'b0}}, i_cin};
    end
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one nibble slice reused over WIDTH/4 cycles,
// least-significant nibble first, with a registered inter-nibble carry.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NUM_NIB = WIDTH / NIB_W;
    localparam int CNT_W   = cnt_width(NUM_NIB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_partial;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [NIB_W-1:0]   w_nib_sum;
    logic               w_nib_cout;
    logic [WIDTH-1:0]   w_partial_nxt;

    nibble_adder u_nibble_adder (
        .i_a    (r_a_sh[NIB_W-1:0]),
        .i_b    (r_b_sh[NIB_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    assign w_last = (r_state == ST_RUN) && (r_cnt == LAST_CNT);

    // New nibble enters at the top; after NUM_NIB passes the LS nibble sits at bit 0.
    if (NUM_NIB == 1) begin : g_single
        assign w_partial_nxt = w_nib_sum;
    end else begin : g_multi
        assign w_partial_nxt = {w_nib_sum, r_partial[WIDTH-1:NIB_W]};
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = bus.i_start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_nxt = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_state_nxt = bus.i_start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: operand acceptance and next values of the status flags.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: w_accept = bus.i_start;
            ST_DONE: w_accept = bus.i_start;
            default: w_accept = 1'b0;
        endcase
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Operand shift registers, inter-nibble carry, partial sum and pass counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh    <= {WIDTH{1'b0}};
            r_b_sh    <= {WIDTH{1'b0}};
            r_partial <= {WIDTH{1'b0}};
            r_carry   <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_a_sh    <= bus.i_a;
            r_b_sh    <= bus.i_b;
            r_partial <= {WIDTH{1'b0}};
            r_carry   <= bus.i_cin;
            r_cnt     <= {CNT_W{1'b0}};
        end else if (r_state == ST_RUN) begin
            r_a_sh    <= r_a_sh >> NIB_W;
            r_b_sh    <= r_b_sh >> NIB_W;
            r_partial <= w_partial_nxt;
            r_carry   <= w_nib_cout;
            r_cnt     <= w_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end else begin
            r_cnt     <= r_cnt;
        end
    end

    // Result and status registers; results only move on the final pass.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum       <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_last) begin
                r_sum       <= w_partial_nxt;
                r_carry_out <= w_nib_cout;
            end else begin
                r_sum       <= r_sum;
                r_carry_out <= r_carry_out;
            end
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_sum       = r_sum;
    assign bus.o_carry_out = r_carry_out;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: expected {carry,sum} queued at each accepted request,
// popped and compared whenever the 16-bit instance raises DONE.
module tb_nibble_serial_adder_ctrl;
    localparam int W  = 16;
    localparam int NN = W / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4  ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16.slave));
    nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.i_clk(clk), .i_rst(rst), .bus(bus4.slave));

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] sb[$];
    logic [16:0] mon_exp;
    int          cyc = 0;
    int          last_done = 0;
    bit          have_last = 1'b0;
    bit          spc_on = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (!rst && bus16.o_done === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check_val("sum", 32'(bus16.o_sum), 32'(mon_exp[15:0]));
                check_val("carry_out", 32'(bus16.o_carry_out), 32'(mon_exp[16]));
            end
            if (spc_on) begin
                if (have_last) check_val("done_spacing", 32'(cyc - last_done), 32'(NN + 1));
                last_done = cyc;
                have_last = 1'b1;
            end
        end
    end

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
        bus16.i_start = 1'b1;
        bus16.i_a     = a;
        bus16.i_b     = b;
        bus16.i_cin   = c;
        sb.push_back(model(a, b, c));
    endtask

    task automatic scramble16();
        bus16.i_start = 1'b0;
        bus16.i_a     = 16'($urandom);
        bus16.i_b     = 16'($urandom);
        bus16.i_cin   = 1'($urandom);
    endtask

    task automatic wait_done16(output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus16.o_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Single operation from idle: busy length, held result, one-cycle DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        bit          got;
        int          busy_cnt;
        bit          stable;
        logic [15:0] s0;
        s0 = bus16.o_sum;
        @(posedge clk); #1;
        drive16(a, b, c);
        @(posedge clk); #1;
        scramble16();
        busy_cnt = 0;
        stable   = 1'b1;
        got      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus16.o_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus16.o_busy === 1'b1) busy_cnt++;
            if (bus16.o_sum !== s0) stable = 1'b0;
        end
        check_val("done_seen", 32'(got), 32'd1);
        check_val("busy_cycles", 32'(busy_cnt), 32'(NN));
        check_val("sum_stable_in_run", 32'(stable), 32'd1);
        @(negedge clk);
        check_val("done_width", 32'(bus16.o_done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1;
        bus16.i_start = 1'b0; bus16.i_a = 16'h0; bus16.i_b = 16'h0; bus16.i_cin = 1'b0;
        bus4.i_start  = 1'b0; bus4.i_a  = 4'h0;  bus4.i_b  = 4'h0;  bus4.i_cin  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_sum", 32'(bus16.o_sum), 32'd0);
        check_val("rst_cout", 32'(bus16.o_carry_out), 32'd0);
        check_val("rst_busy", 32'(bus16.o_busy), 32'd0);
        check_val("rst_done", 32'(bus16.o_done), 32'd0);

        do_op(16'h1234, 16'h4321, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1);

        // START during RUN must be ignored.
        @(posedge clk); #1;
        drive16(16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk); #1;
        scramble16();
        @(posedge clk); #1;
        bus16.i_start = 1'b1; bus16.i_a = 16'hFFFF; bus16.i_b = 16'hFFFF; bus16.i_cin = 1'b1;
        @(posedge clk); #1;
        scramble16();
        wait_done16(got);
        check_val("midrun_done_seen", 32'(got), 32'd1);
        repeat (8) @(negedge clk);
        check_val("midrun_single_done", 32'(sb.size()), 32'd0);

        // Reset on the second RUN cycle discards the operation.
        @(posedge clk); #1;
        bus16.i_start = 1'b1; bus16.i_a = 16'h1111; bus16.i_b = 16'h2222; bus16.i_cin = 1'b0;
        @(posedge clk); #1;
        scramble16();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_sum", 32'(bus16.o_sum), 32'd0);
        check_val("midrst_cout", 32'(bus16.o_carry_out), 32'd0);
        check_val("midrst_busy", 32'(bus16.o_busy), 32'd0);
        check_val("midrst_done", 32'(bus16.o_done), 32'd0);
        repeat (8) @(negedge clk);
        check_val("midrst_idle_busy", 32'(bus16.o_busy), 32'd0);
        do_op(16'h0008, 16'h0008, 1'b0);

        // Back-to-back random operations, restarted in each DONE cycle.
        spc_on = 1'b1;
        have_last = 1'b0;
        @(posedge clk); #1;
        drive16(16'($urandom), 16'($urandom), 1'($urandom));
        @(posedge clk); #1;
        scramble16();
        for (int i = 1; i < 100; i++) begin
            wait_done16(got);
            check_val("b2b_done_seen", 32'(got), 32'd1);
            if (!got) break;
            drive16(16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            scramble16();
        end
        wait_done16(got);
        check_val("b2b_last_done", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        spc_on = 1'b0;
        check_val("b2b_queue_empty", 32'(sb.size()), 32'd0);

        // Single-nibble instance: DONE two cycles after START.
        @(posedge clk); #1;
        bus4.i_start = 1'b1; bus4.i_a = 4'h9; bus4.i_b = 4'h8; bus4.i_cin = 1'b1;
        @(posedge clk); #1;
        bus4.i_start = 1'b0; bus4.i_a = 4'h0; bus4.i_b = 4'h0; bus4.i_cin = 1'b0;
        @(negedge clk);
        check_val("w4_busy", 32'(bus4.o_busy), 32'd1);
        check_val("w4_early_done", 32'(bus4.o_done), 32'd0);
        @(negedge clk);
        check_val("w4_done", 32'(bus4.o_done), 32'd1);
        check_val("w4_sum", 32'(bus4.o_sum), 32'h2);
        check_val("w4_cout", 32'(bus4.o_carry_out), 32'd1);
        @(negedge clk);
        check_val("w4_done_width", 32'(bus4.o_done), 32'd0);
        @(posedge clk); #1;
        bus4.i_start = 1'b1; bus4.i_a = 4'h6; bus4.i_b = 4'h3; bus4.i_cin = 1'b0;
        @(posedge clk); #1;
        bus4.i_start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("w4_done2", 32'(bus4.o_done), 32'd1);
        check_val("w4_sum2", 32'(bus4.o_sum), 32'h9);
        check_val("w4_cout2", 32'(bus4.o_carry_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
